// File: rtl/forex_cycle_reader_if.sv
// Bus bundle for the FOREX cycle reader: Avalon-MM read slave plus the
// vertex stream coming from the Bellman-Ford container.
interface forex_cycle_reader_if #(
   parameter int PRED_W = 8
);
   logic              chipselect;
   logic              read;
   logic [2:0]        address;
   logic [31:0]       readdata;
   logic              readdatavalid;
   logic              cyc_valid;
   logic [PRED_W-1:0] cyc_vertex;
   logic              cyc_last;
   logic              cyc_ready;

   modport master (
      output chipselect, read, address, cyc_valid, cyc_vertex, cyc_last,
      input  readdata, readdatavalid, cyc_ready
   );

   modport slave (
      input  chipselect, read, address, cyc_valid, cyc_vertex, cyc_last,
      output readdata, readdatavalid, cyc_ready
   );
endinterface

// File: rtl/forex_cycle_reader.sv
// FOREX read slave: buffers arbitrage cycles from the container and lets HPS
// software poll STATUS and pop vertices; only cycles closed by cyc_last are visible.
module forex_cycle_reader #(
   parameter int PRED_W = 8,
   parameter int DEPTH  = 64
) (
   input logic                  clk,
   input logic                  reset,
   forex_cycle_reader_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic {FILL, DROP} state_t;

   typedef struct packed {
      logic              last;
      logic [PRED_W-1:0] vertex;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, pending;
   logic          overflow;
   state_t        state;
   logic          ready_q, rvalid_q;
   logic [31:0]   rdata_q;

   logic [PW-1:0] count, fill;
   logic          full, empty, push, rd_acc, pop, write_en, commit, pop_last;
   logic          overflow_set, overflow_clr;
   entry_t        head;
   logic [7:0]    pending_sat;
   logic [31:0]   status_word, pop_word, rdata_next;

   assign count        = commit_ptr - rd_ptr;
   assign fill         = wr_ptr - rd_ptr;
   assign full         = (fill == PW'(DEPTH));
   assign empty        = (count == '0);
   assign head         = mem[rd_ptr[AW-1:0]];
   assign push         = bus.cyc_valid & ready_q;
   assign rd_acc       = bus.chipselect & bus.read;
   assign pop          = rd_acc && (bus.address == 3'd1) && !empty;
   assign write_en     = push && (state == FILL) && !full;
   assign commit       = write_en && bus.cyc_last;
   assign pop_last     = pop && head.last;
   assign overflow_set = push && (state == FILL) && full;
   assign overflow_clr = rd_acc && (bus.address == 3'd3);
   assign pending_sat  = (32'(pending) > 32'd255) ? 8'hFF : 8'(pending);
   assign status_word  = {overflow, empty, 6'b0, pending_sat, 16'(count)};

   // An empty POP/PEEK returns only the empty flag, never stale storage.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      pop_word = '0;
      if (empty) begin
         pop_word[31] = 1'b1;
      end else begin
         pop_word[16]         = head.last;
         pop_word[PRED_W-1:0] = head.vertex;
      end
   end

   always_comb begin
      rdata_next = '0;
      case (bus.address)
         3'd0, 3'd3: rdata_next = status_word;
         3'd1, 3'd2: rdata_next = pop_word;
         default:    rdata_next = '0;
      endcase
   end

   // NOTE: storage has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (write_en) mem[wr_ptr[AW-1:0]] <= '{last: bus.cyc_last, vertex: bus.cyc_vertex};
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
      if (reset) begin
         wr_ptr     <= '0;
         commit_ptr <= '0;
         rd_ptr     <= '0;
         pending    <= '0;
         overflow   <= 1'b0;
         state      <= FILL;
         ready_q    <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
      end else begin
         ready_q  <= 1'b1;
         rvalid_q <= rd_acc;
         if (rd_acc) rdata_q <= rdata_next;

         case (state)
            FILL: begin
               if (push) begin
                  if (!full) begin
                     wr_ptr <= wr_ptr + PW'(1);
                     if (bus.cyc_last) commit_ptr <= wr_ptr + PW'(1);
                  end else begin
                     // Overflow rolls back the partial cycle; the rest of it is discarded.
                     wr_ptr <= commit_ptr;
                     if (!bus.cyc_last) state <= DROP;
                  end
               end
            end
            DROP: begin
               if (push && bus.cyc_last) state <= FILL;
            end
            default: state <= FILL;
         endcase

         if (pop) rd_ptr <= rd_ptr + PW'(1);

         case ({commit, pop_last})
            2'b10:   pending <= pending + PW'(1);
            2'b01:   pending <= pending - PW'(1);
            default: pending <= pending;
         endcase

         if (overflow_set)      overflow <= 1'b1;
         else if (overflow_clr) overflow <= 1'b0;
      end
   end

   assign bus.readdata      = rdata_q;
   assign bus.readdatavalid = rvalid_q;
   assign bus.cyc_ready     = ready_q;
endmodule
